// File: rtl/input_port_fifo.sv
// Per-port router input buffer: a flit FIFO plus a head-side framing FSM.
// It drives the arbiter request and pops flits toward the crossbar while granted.
module input_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              out_valid,
  output logic [2:0]        out_flit_id,
  output logic [DATA_W-1:0] out_data,
  output logic              drop_err,
  output logic [1:0]        state_dbg
);

  localparam logic [2:0]  ID_HEADER = 3'b110;
  localparam logic [2:0]  ID_BODY   = 3'b010;
  localparam logic [2:0]  ID_TAIL   = 3'b011;
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [2:0]        id_mem   [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_data;

  // Handshakes: a flit transfers in on a cycle with in_valid && in_ready, and out
  // to the crossbar on a cycle with out_valid && grant; neither side looks ahead.
  assign empty     = (count == '0);
  assign in_ready  = (count != FULL);
  assign push      = in_valid && in_ready;
  assign head_id   = id_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  assign req         = (state != IDLE);
  assign out_valid   = !empty && (state != IDLE) && grant;
  assign flit_id     = empty ? 3'b000 : head_id;
  assign out_flit_id = empty ? 3'b000 : head_id;
  assign out_data    = empty ? '0 : head_data;
  assign state_dbg   = state;

  // Non-header flits in IDLE are discarded unconditionally; inside a packet only
  // BODY/TAIL are forwarded and anything else is popped as an error while granted.
  always_comb begin
    pop  = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && head_id != ID_HEADER) begin
          pop  = 1'b1;
          drop = 1'b1;
        end
      end
      REQ: pop = grant && !empty;
      SEND: begin
        if (grant && !empty) begin
          pop  = 1'b1;
          drop = (head_id != ID_BODY) && (head_id != ID_TAIL);
        end
      end
      default: begin
        pop  = 1'b0;
        drop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
      id_mem[wr_ptr]   <= in_flit_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      length   <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      drop_err <= drop;
      case (state)
        IDLE: begin
          if (!empty && head_id == ID_HEADER) begin
            state  <= REQ;
            length <= head_data[11:0];
          end
        end
        REQ:     if (grant) state <= SEND;
        SEND:    if (pop && head_id == ID_TAIL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
